// File: rtl/axi_decerr_slave.sv
// axi_decerr_slave: default AXI4 slave answering every burst with DECERR, plus error counter and last faulting address
module axi_decerr_slave #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [ID_WIDTH-1:0]     s_awid,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic [7:0]              s_awlen,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wlast,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [ID_WIDTH-1:0]     s_bid,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ID_WIDTH-1:0]     s_arid,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic [7:0]              s_arlen,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [ID_WIDTH-1:0]     s_rid,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rlast,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic [15:0]             err_count,
   output logic [ADDR_WIDTH-1:0]   last_err_addr,
   output logic                    last_err_write
);
   localparam logic [0:0] R_IDLE = 1'd0;
   localparam logic [0:0] R_DATA = 1'd1;
   localparam logic [1:0] W_ADDR = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   logic [0:0]          r_state;
   logic [7:0]          r_cnt;
   logic [ID_WIDTH-1:0] r_id;
   logic [1:0]          w_state;
   logic [ID_WIDTH-1:0] w_id;
   logic                ar_hs, aw_hs;
   logic [16:0]         cnt_sum;
   logic                unused;
   // write data, burst length of writes and strobes carry no meaning for an error sink
   assign unused = ^{s_awlen, s_wdata, s_wstrb};
   assign s_arready = r_state == R_IDLE;
   assign s_rvalid  = r_state == R_DATA;
   assign s_rlast   = s_rvalid && r_cnt == 8'd0;
   assign s_rresp   = s_rvalid ? 2'b11 : 2'b00;
   assign s_rdata   = '0;
   assign s_rid     = r_id;
   assign s_awready = w_state == W_ADDR;
   assign s_wready  = w_state == W_DATA;
   assign s_bvalid  = w_state == W_RESP;
   assign s_bresp   = s_bvalid ? 2'b11 : 2'b00;
   assign s_bid     = w_id;
   assign ar_hs     = s_arvalid && s_arready;
   assign aw_hs     = s_awvalid && s_awready;
   assign cnt_sum   = {1'b0, err_count} + {15'd0, ar_hs} + {15'd0, aw_hs};
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state <= R_IDLE;
         r_cnt   <= '0;
         r_id    <= '0;
      end else if (r_state == R_IDLE) begin
         if (s_arvalid) begin
            r_state <= R_DATA;
            r_cnt   <= s_arlen;
            r_id    <= s_arid;
         end
      end else if (s_rready) begin
         r_cnt <= r_cnt - 8'd1;
         if (r_cnt == 8'd0) r_state <= R_IDLE;
      end
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         w_state <= W_ADDR;
         w_id    <= '0;
      end else if (w_state == W_ADDR && s_awvalid) begin
         w_state <= W_DATA;
         w_id    <= s_awid;
      end else if (w_state == W_DATA && s_wvalid && s_wlast) begin
         w_state <= W_RESP;
      end else if (w_state == W_RESP && s_bready) begin
         w_state <= W_ADDR;
      end
   end
   // write wins the address capture when both channels handshake together
   always_ff @(posedge aclk) begin
      if (areset) begin
         err_count      <= '0;
         last_err_addr  <= '0;
         last_err_write <= 1'b0;
      end else begin
         err_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
         if (aw_hs) begin
            last_err_addr  <= s_awaddr;
            last_err_write <= 1'b1;
         end else if (ar_hs) begin
            last_err_addr  <= s_araddr;
            last_err_write <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axi_decerr_slave.sv
// tb_axi_decerr_slave: directed checks of the DECERR slave, sampled on the falling edge
module tb_axi_decerr_slave;
   logic        clk = 1'b0;
   logic        areset;
   logic [3:0]  s_awid, s_arid, s_bid, s_rid;
   logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, last_err_addr;
   logic [7:0]  s_awlen, s_arlen;
   logic [3:0]  s_wstrb;
   logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
   logic [1:0]  s_bresp, s_rresp;
   logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
   logic [15:0] err_count;
   logic        last_err_write;
   int          checks = 0;
   int          errors = 0;
   always #5 clk = ~clk;
   axi_decerr_slave dut (
      .aclk(clk), .areset(areset),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .err_count(err_count), .last_err_addr(last_err_addr), .last_err_write(last_err_write)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_reset_values(input string tag);
      check({tag, "_arready"}, s_arready, 1);
      check({tag, "_awready"}, s_awready, 1);
      check({tag, "_wready"}, s_wready, 0);
      check({tag, "_rvalid"}, s_rvalid, 0);
      check({tag, "_bvalid"}, s_bvalid, 0);
      check({tag, "_rlast"}, s_rlast, 0);
      check({tag, "_rdata"}, s_rdata, 0);
      check({tag, "_rresp"}, s_rresp, 0);
      check({tag, "_bresp"}, s_bresp, 0);
      check({tag, "_rid"}, s_rid, 0);
      check({tag, "_bid"}, s_bid, 0);
      check({tag, "_err_count"}, err_count, 0);
      check({tag, "_last_addr"}, last_err_addr, 0);
      check({tag, "_last_write"}, last_err_write, 0);
   endtask
   initial begin
      int beats, cyc;
      logic stall;
      logic [3:0] held_rid;
      logic held_rlast;
      areset = 1'b1;
      {s_awid, s_awaddr, s_awlen, s_awvalid, s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready} = '0;
      {s_arid, s_araddr, s_arlen, s_arvalid, s_rready} = '0;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      areset = 1'b0;
      // single read
      s_arvalid = 1'b1; s_arid = 4'h5; s_araddr = 32'h4000_1234; s_arlen = 8'd0; s_rready = 1'b1;
      @(negedge clk);
      s_arvalid = 1'b0;
      check("rd1_rvalid", s_rvalid, 1);
      check("rd1_rid", s_rid, 4'h5);
      check("rd1_rdata", s_rdata, 0);
      check("rd1_rresp", s_rresp, 2'b11);
      check("rd1_rlast", s_rlast, 1);
      check("rd1_arready", s_arready, 0);
      check("rd1_err_count", err_count, 1);
      check("rd1_last_addr", last_err_addr, 32'h4000_1234);
      check("rd1_last_write", last_err_write, 0);
      @(negedge clk);
      check("rd1_done_rvalid", s_rvalid, 0);
      check("rd1_done_arready", s_arready, 1);
      // 16-beat burst, rready toggling
      s_arvalid = 1'b1; s_arid = 4'h3; s_araddr = 32'h4000_2000; s_arlen = 8'd15; s_rready = 1'b0;
      @(negedge clk);
      s_arvalid = 1'b0;
      beats = 0; stall = 1'b0; held_rid = '0; held_rlast = 1'b0;
      for (cyc = 0; cyc < 60 && beats < 16; cyc++) begin
         check("brst_rvalid", s_rvalid, 1);
         check("brst_rid", s_rid, 4'h3);
         check("brst_rlast", s_rlast, beats == 15);
         if (stall) begin
            check("brst_hold_rid", s_rid, held_rid);
            check("brst_hold_rlast", s_rlast, held_rlast);
         end
         s_rready = cyc[0];
         stall = !s_rready;
         held_rid = s_rid; held_rlast = s_rlast;
         if (s_rready) beats++;
         @(negedge clk);
      end
      check("brst_beats", beats, 16);
      check("brst_end_rvalid", s_rvalid, 0);
      check("brst_end_arready", s_arready, 1);
      check("brst_err_count", err_count, 2);
      // write with W presented before AW
      s_bready = 1'b1; s_wvalid = 1'b1; s_wlast = 1'b0; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("wr_early_wready", s_wready, 0);
      end
      s_awvalid = 1'b1; s_awid = 4'hA; s_awaddr = 32'h5000_0040; s_awlen = 8'd3;
      @(negedge clk);
      s_awvalid = 1'b0;
      check("wr_err_count", err_count, 3);
      check("wr_last_addr", last_err_addr, 32'h5000_0040);
      check("wr_last_write", last_err_write, 1);
      for (int i = 0; i < 4; i++) begin
         check("wr_wready", s_wready, 1);
         check("wr_bvalid_early", s_bvalid, 0);
         s_wlast = i == 3;
         @(negedge clk);
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
      check("wr_bvalid", s_bvalid, 1);
      check("wr_bid", s_bid, 4'hA);
      check("wr_bresp", s_bresp, 2'b11);
      check("wr_wready_off", s_wready, 0);
      @(negedge clk);
      check("wr_done_bvalid", s_bvalid, 0);
      check("wr_done_awready", s_awready, 1);
      // simultaneous AR and AW
      s_arvalid = 1'b1; s_arid = 4'h1; s_araddr = 32'h1fa0_0000; s_arlen = 8'd0; s_rready = 1'b1;
      s_awvalid = 1'b1; s_awid = 4'h2; s_awaddr = 32'h1fa0_0010;
      @(negedge clk);
      s_arvalid = 1'b0; s_awvalid = 1'b0;
      check("both_err_count", err_count, 5);
      check("both_last_addr", last_err_addr, 32'h1fa0_0010);
      check("both_last_write", last_err_write, 1);
      check("both_rvalid", s_rvalid, 1);
      check("both_rid", s_rid, 4'h1);
      check("both_wready", s_wready, 1);
      s_wvalid = 1'b1; s_wlast = 1'b1;
      @(negedge clk);
      s_wvalid = 1'b0; s_wlast = 1'b0;
      check("both_rd_done", s_rvalid, 0);
      check("both_bvalid", s_bvalid, 1);
      check("both_bid", s_bid, 4'h2);
      @(negedge clk);
      check("both_wr_done", s_bvalid, 0);
      check("both_awready", s_awready, 1);
      // reset during beat 3 of an 8-beat burst
      s_arvalid = 1'b1; s_arid = 4'h7; s_araddr = 32'h6000_0000; s_arlen = 8'd7;
      @(negedge clk);
      s_arvalid = 1'b0;
      repeat (3) @(negedge clk);
      check("rstb_beat3_rvalid", s_rvalid, 1);
      areset = 1'b1;
      @(negedge clk);
      check_reset_values("rstb");
      areset = 1'b0;
      @(negedge clk);
      check("rstb_no_residual", s_rvalid, 0);
      s_arvalid = 1'b1; s_arid = 4'h6; s_araddr = 32'h6000_0100; s_arlen = 8'd1;
      @(negedge clk);
      s_arvalid = 1'b0;
      check("rstb_new_rid", s_rid, 4'h6);
      check("rstb_new_rlast0", s_rlast, 0);
      check("rstb_new_err_count", err_count, 1);
      @(negedge clk);
      check("rstb_new_rlast1", s_rlast, 1);
      @(negedge clk);
      check("rstb_new_done", s_rvalid, 0);
      // saturation: both channels kept busy at full rate
      s_arvalid = 1'b1; s_arlen = 8'd0; s_rready = 1'b1;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_wlast = 1'b1; s_bready = 1'b1;
      for (cyc = 0; cyc < 90000 && err_count != 16'hFFFF; cyc++) @(negedge clk);
      check("sat_reached", err_count, 16'hFFFF);
      repeat (20) @(negedge clk);
      check("sat_hold", err_count, 16'hFFFF);
      s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_decerr_slave.md
# axi_decerr_slave

Default AXI4 slave terminating every transaction the SoC address decoder routes to no real peripheral (unmapped holes, unimplemented controllers). Sits directly downstream of the CPU-side AXI demux on the error port. Completes reads and writes with protocol-correct bursts and DECERR responses, so the bus never hangs. Exposes a saturating error counter and the last faulting address for the config/debug registers.

## Interface
- ID_WIDTH, 4, AXI ID width of the slave port
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, read data width (returned data is all zeros)
- aclk  in  1  single clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- s_awid/s_awaddr/s_awlen  in  ID_WIDTH/ADDR_WIDTH/8  write address channel (size, burst, lock, cache, prot not present; ignored)
- s_awvalid in 1, s_awready out 1  AW handshake
- s_wdata/s_wstrb/s_wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data, discarded
- s_wvalid in 1, s_wready out 1  W handshake
- s_bid out ID_WIDTH, s_bresp out 2, s_bvalid out 1, s_bready in 1  write response
- s_arid/s_araddr/s_arlen  in  ID_WIDTH/ADDR_WIDTH/8  read address channel
- s_arvalid in 1, s_arready out 1  AR handshake
- s_rid out ID_WIDTH, s_rdata out DATA_WIDTH, s_rresp out 2, s_rlast out 1, s_rvalid out 1, s_rready in 1  read data
- err_count  out  16  accepted AR+AW count, saturating
- last_err_addr  out  ADDR_WIDTH  address of most recent accepted AR/AW
- last_err_write  out  1  1 if last_err_addr came from AW

## Operation
- Read FSM, states R_IDLE, R_DATA. s_arready = (state==R_IDLE). AR handshake in R_IDLE: latch arid, load beat counter = arlen, go R_DATA.
- R_DATA: s_rvalid=1, s_rdata=0, s_rresp=2'b11, s_rid=latched id, s_rlast=(counter==0). Each R handshake: counter-1; handshake with rlast -> R_IDLE. Outputs hold stable while rvalid&!rready.
- Write FSM, states W_ADDR, W_DATA, W_RESP. s_awready=(W_ADDR), s_wready=(W_DATA), s_bvalid=(W_RESP).
- W_ADDR: AW handshake latches awid -> W_DATA. W beats presented before AW are not accepted (wready=0).
- W_DATA: accept and discard beats; termination is by s_wlast, not by awlen. Handshake with wlast=1 -> W_RESP.
- W_RESP: s_bresp=2'b11, s_bid=latched id; B handshake -> W_ADDR.
- Read and write FSMs fully independent; one outstanding read and one outstanding write at most.
- err_count: +1 per AR handshake, +1 per AW handshake, +2 if both in same cycle; saturates at 16'hFFFF (never wraps).
- last_err_addr/last_err_write: updated on every AR or AW handshake; on simultaneous AR and AW, write wins (awaddr, write=1).

## Timing
- Reset values: s_arready=1, s_awready=1, s_wready=0, s_rvalid=0, s_bvalid=0, s_rlast=0, s_rdata=0, s_rresp=0, s_bresp=0, s_rid=0, s_bid=0, err_count=0, last_err_addr=0, last_err_write=0. FSMs to R_IDLE/W_ADDR.
- Reset mid-burst aborts transaction immediately; no residual beats or responses after reset deasserts.
- AR handshake cycle n -> first rvalid cycle n+1. Burst of arlen+1 beats with rready held high: one beat per cycle, rlast at cycle n+1+arlen, arready high again cycle n+2+arlen.
- AW handshake n -> wready n+1; wlast handshake m -> bvalid m+1; B handshake k -> awready k+1.
- arready/awready/wready/valid signals are functions of registered state only; no combinational path from any input valid/ready to an output.
- Counter and last_err_* update the cycle after the handshake.

## Test plan
- Single read: arid=4'h5, arlen=0, rready=1 -> one beat cycle+1, rid=5, rdata=0, rresp=2'b11, rlast=1; err_count=1, last_err_addr=araddr, last_err_write=0.
- Burst read arlen=15 with rready toggling every other cycle -> exactly 16 beats, rlast only on 16th, outputs stable during stalls.
- Write: wvalid asserted 3 cycles before awvalid, awid=4'hA, 4 beats -> no W accepted before AW, bvalid one cycle after wlast, bid=A, bresp=2'b11.
- AR and AW handshake same cycle (araddr=1fa0_0000, awaddr=1fa0_0010) -> err_count +2, last_err_addr=1fa0_0010, last_err_write=1; both complete independently.
- Saturation: force 65537 single reads -> err_count holds 16'hFFFF.
- areset asserted mid read burst (beat 3 of 8) -> next cycle rvalid=0, arready=1, all outputs at reset values; new AR then served normally.
